// File: rtl/gan_pkg.sv
// gan_pkg: Q8.24 constants, pattern masks, detector weights and saturate/clamp helpers for the GAN demonstrator.
package gan_pkg;
    localparam int FRAC_BITS = 24;
    localparam int ACC_W = 40;
    localparam logic signed [31:0] Q_ONE = 32'sh0100_0000;
    localparam logic [8:0] CIRCLE_MASK = 9'b111101111;
    localparam logic [8:0] CROSS_MASK = 9'b101010101;
    localparam logic signed [31:0] W_CIRC = 32'sh0020_0000;
    localparam logic signed [31:0] W_CROSS = 32'sh0033_3333;

    function automatic logic signed [31:0] sat_word(input logic signed [32:0] x);
        sat_word = x > 33'sh0_7FFF_FFFF ? 32'sh7FFF_FFFF :
                   x < 33'sh1_8000_0000 ? 32'sh8000_0000 : x[31:0];
    endfunction

    function automatic logic signed [31:0] clamp_unit(input logic signed [ACC_W-1:0] x);
        clamp_unit = x < 40'sh00_0000_0000 ? 32'sh0000_0000 :
                     x > 40'sh00_0100_0000 ? Q_ONE : x[31:0];
    endfunction
endpackage

// File: rtl/gan_discriminator.sv
// gan_discriminator: weighted sum of the 9 registered pixels against the selected pattern, hard-sigmoid clamped and registered.
module gan_discriminator
    import gan_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    choice_d,
    input  logic signed [WIDTH-1:0] pix [9],
    output logic signed [WIDTH-1:0] score
);
    logic [8:0] mask;
    logic signed [WIDTH-1:0] w_mag;
    logic signed [WIDTH-1:0] w [9];
    logic signed [ACC_W-1:0] acc;

    always_comb begin
        mask = choice_d ? CROSS_MASK : CIRCLE_MASK;
        w_mag = choice_d ? W_CROSS : W_CIRC;
        acc = '0;
        for (int k = 0; k < 9; k++) begin
            w[k] = mask[k] ? w_mag : -w_mag;
            acc = acc + ACC_W'((64'(pix[k]) * 64'(w[k])) >>> FRAC_BITS);
        end
    end

    always_ff @(posedge clk)
        score <= rst ? '0 : clamp_unit(acc);
endmodule

// File: rtl/gan_top_level.sv
// gan_top_level: generator + pixel registers feeding gan_discriminator; define GAN_PIXEL_CLAMP_EN to clamp pixels to [0, 1.0].
module gan_top_level
    import gan_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    choice,
    input  logic signed [WIDTH-1:0] in_1,
    input  logic signed [WIDTH-1:0] in_2,
    output logic signed [WIDTH-1:0] pixel_1x1,
    output logic signed [WIDTH-1:0] pixel_1x2,
    output logic signed [WIDTH-1:0] pixel_1x3,
    output logic signed [WIDTH-1:0] pixel_2x1,
    output logic signed [WIDTH-1:0] pixel_2x2,
    output logic signed [WIDTH-1:0] pixel_2x3,
    output logic signed [WIDTH-1:0] pixel_3x1,
    output logic signed [WIDTH-1:0] pixel_3x2,
    output logic signed [WIDTH-1:0] pixel_3x3,
    output logic signed [WIDTH-1:0] out_discriminator
);
    logic signed [WIDTH:0] sum [9];
    logic signed [WIDTH-1:0] pix_next [9];
    logic signed [WIDTH-1:0] pix [9];
    logic choice_d;

    always_comb begin
        for (int k = 0; k < 9; k++) begin
            sum[k] = (CIRCLE_MASK[k] ? (WIDTH+1)'(in_1) : '0) + (CROSS_MASK[k] ? (WIDTH+1)'(in_2) : '0);
`ifdef GAN_PIXEL_CLAMP_EN
            pix_next[k] = clamp_unit(ACC_W'(sum[k]));
`else
            pix_next[k] = sat_word(sum[k]);
`endif
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < 9; k++)
            pix[k] <= rst ? '0 : pix_next[k];
        choice_d <= rst ? 1'b0 : choice;
    end

    assign pixel_1x1 = pix[0];
    assign pixel_1x2 = pix[1];
    assign pixel_1x3 = pix[2];
    assign pixel_2x1 = pix[3];
    assign pixel_2x2 = pix[4];
    assign pixel_2x3 = pix[5];
    assign pixel_3x1 = pix[6];
    assign pixel_3x2 = pix[7];
    assign pixel_3x3 = pix[8];

    gan_discriminator #(.WIDTH(WIDTH)) u_disc (
        .clk      (clk),
        .rst      (rst),
        .choice_d (choice_d),
        .pix      (pix),
        .score    (out_discriminator)
    );
endmodule

// File: tb/tb_gan_top_level.sv
// tb_gan_top_level: directed stimulus, per-cycle check against a pattern-level model, plus literal expectations.
module tb_gan_top_level;
    localparam logic signed [31:0] Q = 32'sh0100_0000;
    localparam logic [8:0] CIRC = 9'b111101111;
    localparam logic [8:0] CROSS = 9'b101010101;

    logic clk = 1'b0;
    logic rst;
    logic choice;
    logic signed [31:0] in_1, in_2;
    logic signed [31:0] dpix [9];
    logic signed [31:0] dscore;

    int n_checks = 0;
    int n_fail = 0;
    bit check_en = 0;

    longint m_pix [9];
    longint m_score;
    bit m_ch;

    always #5 clk = ~clk;

    gan_top_level dut (
        .clk               (clk),
        .rst               (rst),
        .choice            (choice),
        .in_1              (in_1),
        .in_2              (in_2),
        .pixel_1x1         (dpix[0]),
        .pixel_1x2         (dpix[1]),
        .pixel_1x3         (dpix[2]),
        .pixel_2x1         (dpix[3]),
        .pixel_2x2         (dpix[4]),
        .pixel_2x3         (dpix[5]),
        .pixel_3x1         (dpix[6]),
        .pixel_3x2         (dpix[7]),
        .pixel_3x3         (dpix[8]),
        .out_discriminator (dscore)
    );

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, expected %h", nm, $time, got, exp);
        end
    endtask

    function automatic longint gen_pixel(input int k, input longint a, input longint b);
        longint s = (CIRC[k] ? a : 0) + (CROSS[k] ? b : 0);
`ifdef GAN_PIXEL_CLAMP_EN
        return s < 0 ? 0 : (s > 64'sh100_0000 ? 64'sh100_0000 : s);
`else
        return s > 64'sh7FFF_FFFF ? 64'sh7FFF_FFFF : (s < -64'sh8000_0000 ? -64'sh8000_0000 : s);
`endif
    endfunction

    function automatic longint score_of(input bit ch);
        longint acc = 0;
        longint wt = ch ? 64'sh33_3333 : 64'sh20_0000;
        logic [8:0] pat = ch ? CROSS : CIRC;
        for (int k = 0; k < 9; k++)
            acc += (m_pix[k] * (pat[k] ? wt : -wt)) >>> 24;
        return acc < 0 ? 0 : (acc > 64'sh100_0000 ? 64'sh100_0000 : acc);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 9; k++) m_pix[k] = 0;
            m_score = 0;
            m_ch = 0;
        end else begin
            m_score = score_of(m_ch);
            for (int k = 0; k < 9; k++) m_pix[k] = gen_pixel(k, longint'(in_1), longint'(in_2));
            m_ch = choice;
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            for (int k = 0; k < 9; k++) chk($sformatf("model_pixel%0d", k), dpix[k], 32'(m_pix[k]));
            chk("model_score", dscore, 32'(m_score));
        end
    end

    task automatic step(input logic signed [31:0] a, input logic signed [31:0] b, input logic ch);
        #1;
        rst = 1'b0;
        in_1 = a;
        in_2 = b;
        choice = ch;
        @(negedge clk);
    endtask

    task automatic all_zero(input string nm);
        for (int k = 0; k < 9; k++) chk($sformatf("%s_pixel%0d", nm, k), dpix[k], 32'h0);
        chk({nm, "_score"}, dscore, 32'h0);
    endtask

    initial begin
        rst = 1'b1;
        choice = 1'b1;
        in_1 = 32'sh0123_4567;
        in_2 = -32'sh0000_0005;
        repeat (3) @(negedge clk);
        all_zero("reset");
        check_en = 1;

        step(0, Q, 0);
        step(0, Q, 0);
        for (int k = 0; k < 9; k++) chk($sformatf("cross_img_pixel%0d", k), dpix[k], CROSS[k] ? 32'h0100_0000 : 32'h0);
        chk("cross_by_circle", dscore, 32'h0060_0000);
        step(0, Q, 1);
        step(0, Q, 1);
        chk("cross_by_cross", dscore, 32'h00FF_FFFF);
        step(Q, 0, 0);
        step(Q, 0, 0);
        chk("circle_img_center", dpix[4], 32'h0);
        chk("circle_by_circle", dscore, 32'h0100_0000);
        step(Q, 0, 1);
        step(Q, 0, 1);
        chk("circle_by_cross", dscore, 32'h0);

        step(Q, 0, 0);
        step(Q, 0, 1);
        chk("alt0", dscore, 32'h0100_0000);
        step(Q, 0, 0);
        chk("alt1", dscore, 32'h0);
        step(Q, 0, 1);
        chk("alt2", dscore, 32'h0100_0000);
        step(Q, 0, 0);
        chk("alt3", dscore, 32'h0);

        step(Q, Q, 0);
        step(Q, Q, 0);
`ifdef GAN_PIXEL_CLAMP_EN
        chk("both_corner", dpix[0], 32'h0100_0000);
        chk("both_score", dscore, 32'h00E0_0000);
`else
        chk("both_corner", dpix[0], 32'h0200_0000);
        chk("both_score", dscore, 32'h0100_0000);
`endif

        step(-Q, Q >>> 1, 1);
        step(32'sh7FFF_FFFF, 32'sh7FFF_FFFF, 0);
        step(32'sh8000_0000, 32'sh8000_0000, 1);
        step(32'sh8000_0000, 32'sh7FFF_FFFF, 0);
        step(-32'sh0030_0000, 32'sh0180_0000, 1);
        step(32'sh0040_0000, -32'sh0010_0000, 0);
        step(32'sh7FFF_FFFF, 0, 1);
        step(0, 0, 0);

        step(Q, 0, 0);
        #1;
        rst = 1'b1;
        @(negedge clk);
        all_zero("midrst0");
        @(negedge clk);
        all_zero("midrst1");
        step(0, Q, 1);
        chk("resume_center", dpix[4], 32'h0100_0000);
        chk("resume_score_zero", dscore, 32'h0);
        step(0, Q, 1);
        chk("resume_score", dscore, 32'h00FF_FFFF);
        step(0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
